// File: rtl/ef_psram_init_seq.sv
// Power-up / re-init sequencer that owns the PSRAM pads and sends RSTIO, WRMR (and EQIO).
// Define EF_PSRAM_INIT_QUAD_EN to append the EQIO frame and leave the device in SQI mode.
module ef_psram_init_seq #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CE_GAP   = 4,
  parameter logic [7:0]  MODE_REG = 8'h40
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       start,
  input  logic       ctrl_sck,
  input  logic       ctrl_ce_n,
  input  logic [3:0] ctrl_dout,
  input  logic [3:0] ctrl_douten,
  output logic       sck,
  output logic       ce_n,
  output logic [3:0] dout,
  output logic [3:0] douten,
  output logic       busy,
  output logic       done
);

  // state | meaning
  // GAP   | ce_n high for CE_GAP cycles, before each frame and before DONE
  // SHIFT | ce_n low, mode-0 shifting of the current frame MSB-first
  // HOLD  | ce_n low, sck low for CLK_DIV cycles after the last bit
  // DONE  | pads pass through from the controller
  typedef enum logic [1:0] {S_GAP, S_SHIFT, S_HOLD, S_DONE} state_t;

`ifdef EF_PSRAM_INIT_QUAD_EN
  localparam logic [1:0] NUM_FRAMES = 2'd3;
`else
  localparam logic [1:0] NUM_FRAMES = 2'd2;
`endif
  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD = 8'(CE_GAP - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] bit_idx, bit_idx_n;
  logic       sck_ph, sck_ph_n;
  logic [1:0] frame, frame_n;
  logic [15:0] word;
  logic [3:0]  top_bit;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_GAP;
      cnt     <= GAP_LOAD;
      bit_idx <= 4'd0;
      sck_ph  <= 1'b0;
      frame   <= 2'd0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      sck_ph  <= sck_ph_n;
      frame   <= frame_n;
    end
  end

  always_comb begin
    word    = 16'h0000;
    top_bit = 4'd7;
    case (frame)
      2'd0: word = 16'h00FF;
      2'd1: begin
        word    = {8'h01, MODE_REG};
        top_bit = 4'd15;
      end
`ifdef EF_PSRAM_INIT_QUAD_EN
      2'd2: word = 16'h0038;
`endif
      default: word = 16'h0000;
    endcase
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    sck_ph_n  = sck_ph;
    frame_n   = frame;
    case (state)
      S_GAP: begin
        if (cnt == 8'd0) begin
          if (frame == NUM_FRAMES) begin
            state_n = S_DONE;
          end else begin
            state_n   = S_SHIFT;
            cnt_n     = DIV_LOAD;
            sck_ph_n  = 1'b0;
            bit_idx_n = top_bit;
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_SHIFT: begin
        if (cnt == 8'd0) begin
          cnt_n = DIV_LOAD;
          if (!sck_ph) begin
            sck_ph_n = 1'b1;
          end else begin
            sck_ph_n = 1'b0;
            if (bit_idx == 4'd0) state_n = S_HOLD;
            else bit_idx_n = bit_idx - 4'd1;
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_HOLD: begin
        if (cnt == 8'd0) begin
          state_n = S_GAP;
          cnt_n   = GAP_LOAD;
          frame_n = frame + 2'd1;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: begin
        if (start) begin
          state_n = S_GAP;
          cnt_n   = GAP_LOAD;
          frame_n = 2'd0;
        end
      end
    endcase
  end

  // RSTIO drives all four lines high so it also works if the device is already in SQI.
  always_comb begin
    sck    = 1'b0;
    ce_n   = 1'b1;
    dout   = 4'h0;
    douten = 4'h0;
    busy   = 1'b1;
    done   = 1'b0;
    case (state)
      S_SHIFT, S_HOLD: begin
        ce_n = 1'b0;
        sck  = (state == S_SHIFT) && sck_ph;
        if (frame == 2'd0) begin
          dout   = 4'hF;
          douten = 4'hF;
        end else begin
          dout   = {3'b000, word[bit_idx]};
          douten = 4'h1;
        end
      end
      S_DONE: begin
        sck    = ctrl_sck;
        ce_n   = ctrl_ce_n;
        dout   = ctrl_dout;
        douten = ctrl_douten;
        busy   = 1'b0;
        done   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ef_psram_init_seq.sv
// Scoreboard bench for ef_psram_init_seq: frame timing, captured bytes, pass-through, resets, restarts.
// A second instance with CLK_DIV=1, CE_GAP=1, MODE_REG=0 checks the fast corner.
module tb_ef_psram_init_seq;
  localparam int         CLK_DIV = 2;
  localparam int         CE_GAP  = 4;
  localparam logic [7:0] MODE    = 8'h40;
`ifdef EF_PSRAM_INIT_QUAD_EN
  localparam bit QUAD = 1'b1;
`else
  localparam bit QUAD = 1'b0;
`endif

  logic HCLK = 1'b0, HRESETn = 1'b0, start = 1'b0;
  logic ctrl_sck = 1'b0, ctrl_ce_n = 1'b1;
  logic [3:0] ctrl_dout = 4'h0, ctrl_douten = 4'h0;
  logic sck, ce_n, busy, done;
  logic [3:0] dout, douten;

  logic rst_f = 1'b0;
  logic f_sck, f_ce_n, f_busy, f_done;
  logic [3:0] f_dout, f_douten;

  ef_psram_init_seq dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
    .ctrl_sck(ctrl_sck), .ctrl_ce_n(ctrl_ce_n), .ctrl_dout(ctrl_dout), .ctrl_douten(ctrl_douten),
    .sck(sck), .ce_n(ce_n), .dout(dout), .douten(douten), .busy(busy), .done(done)
  );

  ef_psram_init_seq #(.CLK_DIV(1), .CE_GAP(1), .MODE_REG(8'h00)) dut_fast (
    .HCLK(HCLK), .HRESETn(rst_f), .start(1'b0),
    .ctrl_sck(1'b1), .ctrl_ce_n(1'b0), .ctrl_dout(4'h5), .ctrl_douten(4'hA),
    .sck(f_sck), .ce_n(f_ce_n), .dout(f_dout), .douten(f_douten), .busy(f_busy), .done(f_done)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int          start_c;
    int          end_c;
    logic [15:0] data;
    int          nbits;
  } frame_t;

  frame_t exp_q[$];
  int     done_q[$];

  function automatic int frame_len(int nbits, int div);
    return (2 * nbits + 1) * div;
  endfunction

  // origin = edge at which the sequencer enters its first gap; cycle numbers are rising-edge counts
  function automatic void push_seq(int origin);
    int t;
    int nf;
    frame_t fr;
    t  = origin + CE_GAP;
    nf = QUAD ? 3 : 2;
    for (int f = 0; f < nf; f++) begin
      if (f == 0) begin fr.data = 16'h00FF; fr.nbits = 8; end
      else if (f == 1) begin fr.data = {8'h01, MODE}; fr.nbits = 16; end
      else begin fr.data = 16'h0038; fr.nbits = 8; end
      fr.start_c = t + 1;
      fr.end_c   = t + frame_len(fr.nbits, CLK_DIV);
      exp_q.push_back(fr);
      t = fr.end_c + CE_GAP;
    end
    done_q.push_back(t);
  endfunction

  // ---------------- monitor / slave model ----------------
  bit          in_frame = 0;
  int          f_start, f_last, nb, sck_edges;
  logic [15:0] sh;
  bit          all_quad, all_single;
  logic        prev_sck = 1'b0, prev_done = 1'b0;
  bit          slave_quad = 0;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      in_frame  = 0;
      prev_sck  = 1'b0;
      prev_done = 1'b0;
      sck_edges = 0;
    end else begin
      if (busy) begin
        if (!ce_n) begin
          if (!in_frame) begin
            in_frame = 1; f_start = cyc + 1; sh = 16'h0; nb = 0;
            all_quad = 1; all_single = 1;
          end
          f_last = cyc + 1;
          if (sck && !prev_sck) begin
            sh = {sh[14:0], dout[0]}; nb++; sck_edges++;
          end
          if (!(douten == 4'hF && dout == 4'hF)) all_quad = 0;
          if (!(douten == 4'h1 && dout[3:1] == 3'b000)) all_single = 0;
        end else if (in_frame) begin
          in_frame = 0;
          check("frame_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            frame_t e;
            e = exp_q.pop_front();
            check("frame_start", f_start, e.start_c);
            check("frame_end", f_last, e.end_c);
            check("frame_bits", nb, e.nbits);
            check("frame_data", sh, e.data);
            check("frame_pins", (e.data == 16'h00FF) ? all_quad : all_single, 1'b1);
          end
          if (nb == 8 && sh[7:0] == 8'hFF) slave_quad = 0;
          if (nb == 8 && sh[7:0] == 8'h38) slave_quad = 1;
        end
        prev_sck = sck;
      end
      if (done && !prev_done) begin
        check("done_expected", done_q.size() > 0, 1'b1);
        if (done_q.size() > 0) check("done_edge", cyc, done_q.pop_front());
        check("done_busy_low", busy, 1'b0);
        check("slave_quad", slave_quad, QUAD);
        check("sck_edges", sck_edges, QUAD ? 32 : 24);
        sck_edges = 0;
      end
      prev_done = done;
    end
  end

  // Controller-side stimulus: random while busy (must be ignored), a fixed pattern in pass-through mode.
  bit pt_mode = 0;
  int pt_cnt  = 0;
  always @(negedge HCLK) begin
    if (pt_mode) begin
      ctrl_sck    = ~ctrl_sck;
      ctrl_ce_n   = 1'b0;
      ctrl_dout   = (pt_cnt < 4) ? 4'hA : 4'($urandom);
      ctrl_douten = (pt_cnt < 4) ? 4'hF : 4'($urandom);
      pt_cnt++;
    end else begin
      ctrl_sck    = 1'($urandom);
      ctrl_ce_n   = 1'($urandom);
      ctrl_dout   = 4'($urandom);
      ctrl_douten = 4'($urandom);
    end
  end

  // ---------------- fast-corner instance ----------------
  int          fl_lows = 0, fl_edges = 0, f_done_edge = -1;
  logic [31:0] f_bits = 32'h0;
  logic        f_prev_sck = 1'b0, f_prev_done = 1'b0;
  bit          fast_finished = 0;

  always @(negedge HCLK) begin
    if (rst_f) begin
      if (f_busy && !f_ce_n) begin
        fl_lows++;
        if (f_sck && !f_prev_sck) begin f_bits = {f_bits[30:0], f_dout[0]}; fl_edges++; end
      end
      if (f_done && !f_prev_done && f_done_edge < 0) f_done_edge = cyc;
      f_prev_sck  = f_sck;
      f_prev_done = f_done;
    end
  end

  initial begin
    int fo, g, nf_bits, lows_exp, done_exp;
    repeat (3) @(posedge HCLK);
    #2 rst_f = 1'b1;
    fo = cyc;
    g  = 0;
    while (f_done_edge < 0 && g < 500) begin @(negedge HCLK); g++; end
    check("fast_timeout", g < 500, 1'b1);
    lows_exp = frame_len(8, 1) + frame_len(16, 1) + (QUAD ? frame_len(8, 1) : 0);
    done_exp = fo + lows_exp + (QUAD ? 4 : 3) * 1;
    nf_bits  = QUAD ? 32 : 24;
    check("fast_done_edge", f_done_edge, done_exp);
    check("fast_ce_low_cycles", fl_lows, lows_exp);
    check("fast_sck_edges", fl_edges, nf_bits);
    check("fast_bytes", f_bits, QUAD ? 32'hFF010038 : 32'h00FF0100);
    fast_finished = 1;
  end

  // ---------------- main stimulus ----------------
  task automatic wait_cyc(input int target);
    int g = 0;
    while (cyc < target && g < 2000) begin @(posedge HCLK); #1; g++; end
    check("wait_cyc_timeout", g < 2000, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while (!(done && done_q.size() == 0) && g < 1000) begin @(negedge HCLK); g++; end
    check(name, g < 1000, 1'b1);
    check({name, "_frames_drained"}, exp_q.size(), 0);
  endtask

  task automatic release_reset(input bit with_start);
    @(posedge HCLK);
    #2;
    start   = with_start;
    HRESETn = 1'b1;
    push_seq(cyc);
    @(posedge HCLK);
    #1 start = 1'b0;
  endtask

  task automatic reset_now(input string name);
    #1 HRESETn = 1'b0;
    #1;
    check({name, "_ce_n"}, ce_n, 1'b1);
    check({name, "_sck"}, sck, 1'b0);
    check({name, "_douten"}, douten, 4'h0);
    check({name, "_dout"}, dout, 4'h0);
    check({name, "_busy"}, busy, 1'b1);
    check({name, "_done"}, done, 1'b0);
    exp_q.delete();
    done_q.delete();
    repeat (3) @(posedge HCLK);
  endtask

  initial begin
    int origin, r;
    #1;
    check("rst_ce_n", ce_n, 1'b1);
    check("rst_sck", sck, 1'b0);
    check("rst_dout", dout, 4'h0);
    check("rst_douten", douten, 4'h0);
    check("rst_busy", busy, 1'b1);
    check("rst_done", done, 1'b0);
    repeat (3) @(posedge HCLK);

    release_reset(1'b0);
    wait_done("seq1");

    pt_mode = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge HCLK);
      #1;
      check("pt_sck", sck, ctrl_sck);
      check("pt_ce_n", ce_n, ctrl_ce_n);
      check("pt_dout", dout, ctrl_dout);
      check("pt_douten", douten, ctrl_douten);
      check("pt_busy", busy, 1'b0);
    end
    pt_mode = 0;

    // reset at cycle 60, inside WRMR; start held high across release must be ignored
    @(posedge HCLK);
    #2 reset_now("rst_pre");
    release_reset(1'b0);
    origin = cyc - 1;
    wait_cyc(origin + 60);
    check("wrmr_active", ce_n, 1'b0);
    reset_now("rst60");
    release_reset(1'b1);
    wait_done("seq_after_rst60");

    // restart from DONE, second pulse during frame 1 ignored
    repeat ($urandom_range(0, 10)) @(posedge HCLK);
    @(negedge HCLK);
    start  = 1'b1;
    origin = cyc + 1;
    push_seq(origin);
    @(posedge HCLK);
    #1 start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_done", done, 1'b0);
    wait_cyc(origin + $urandom_range(43, 100));
    @(negedge HCLK);
    start = 1'b1;
    @(posedge HCLK);
    #1 start = 1'b0;
    wait_done("seq_restart");

    // random truncating resets, then a full run
    for (int k = 0; k < 3; k++) begin
      @(posedge HCLK);
      #2 reset_now("rst_rand_pre");
      release_reset(1'b0);
      origin = cyc - 1;
      r = $urandom_range(5, 145);
      wait_cyc(origin + r);
      reset_now("rst_rand");
      release_reset(1'b0);
      wait_done("seq_rand");
    end

    begin
      int g = 0;
      while (!fast_finished && g < 1000) begin @(posedge HCLK); g++; end
      check("fast_finished", fast_finished, 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ef_psram_init_seq.md
# ef_psram_init_seq

Power-up and re-initialisation sequencer for the quad-SPI PSRAM/SRAM attached to `EF_PSRAM_CTRL`. It sits between the controller's pin outputs and the `sck`/`ce_n`/`dout`/`douten` pads. After reset, or on request, it owns the pins and issues the mode-setup command frames: RSTIO, WRMR, and optionally EQIO. It then returns the pins to the controller through a pass-through mux. While it owns the pins it raises `busy`, and the bus wrapper uses `busy` to stall accesses by holding HREADYOUT low.

## Interface
Parameters:
- `CLK_DIV`, default 2: sck half-period in HCLK cycles; legal range 1–255.
- `CE_GAP`, default 4: ce_n-high cycles before each frame and after the last frame; legal range 1–255.
- `MODE_REG`, default 8'h40: data byte sent in WRMR; 8'h40 selects sequential mode.

Ports:
- `HCLK`  in  1  clock; all state changes on the rising edge.
- `HRESETn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; restarts the sequence when `done`=1; ignored while `busy`=1.
- `ctrl_sck`  in  1  controller sck.
- `ctrl_ce_n`  in  1  controller chip enable.
- `ctrl_dout`  in  4  controller data out.
- `ctrl_douten`  in  4  controller output enables.
- `sck`  out  1  pad sck.
- `ce_n`  out  1  pad chip enable.
- `dout`  out  4  pad data out.
- `douten`  out  4  pad output enables.
- `busy`  out  1  sequencer owns the pins.
- `done`  out  1  sequence complete; pins pass through from the controller.

## Operation
- States and transitions:
  - `GAP`: ce_n=1, sck=0, wait `CE_GAP` cycles, then go to `SHIFT` for the next frame, or to `DONE` after the last frame.
  - `SHIFT`: ce_n=0; send N bits MSB-first.
  - `HOLD`: sck=0, ce_n=0 for `CLK_DIV` cycles, then go to `GAP`.
  - `DONE`: busy=0, done=1; outputs are combinational pass-through of the `ctrl_*` inputs. `start` moves to `GAP` (first frame), busy=1, done=0.
- SPI mode 0 shifting:
  - sck idles low.
  - Each bit is a low phase of `CLK_DIV` cycles with the bit valid, then a high phase of `CLK_DIV` cycles.
  - Data changes only while sck is low; the first bit is valid from the cycle ce_n falls.
  - Frame length with ce_n low = (2N+1)·`CLK_DIV` cycles.
- Frame 0, RSTIO 8'hFF, N=8:
  - dout=4'b1111, douten=4'b1111 for the whole frame.
  - This exits SQI if the device is already in quad mode; in SPI mode it is a no-op.
- Frame 1, WRMR 8'h01 followed by `MODE_REG`, N=16:
  - Serial on dout[0]; douten=4'b0001; dout[3:1]=0.
- Frame 2, EQIO 8'h38, N=8, same pin usage as WRMR:
  - Issued only under `EF_PSRAM_INIT_QUAD_EN`.
- During the sequence, all `ctrl_*` inputs are ignored. `din` is not touched.
- Reset:
  - Asynchronous `HRESETn` low forces ce_n=1, sck=0, dout=0, douten=0, busy=1, done=0, state=`GAP` with a fresh count.
  - The sequence restarts from frame 0 on release.
  - A reset mid-frame truncates the frame; ce_n rises immediately.

## Timing
- Cycle 1 = first HCLK rising edge after HRESETn deasserts.
- With defaults and quad enabled:
  - Frame 0 ce_n low: cycles 5–38.
  - Frame 1 ce_n low: cycles 43–108.
  - Frame 2 ce_n low: cycles 113–146.
  - done=1 and busy=0 from the edge of cycle 150.
- Without quad: done=1 from cycle 112.
- General completion cycle: Σ(frames)·(2N+1)·`CLK_DIV` + (frames+1)·`CE_GAP`.
- `start` in `DONE`: busy=1 from the next edge; the first frame's ce_n falls `CE_GAP` cycles later.
- `start` coincident with reset release is ignored.
- Pass-through in `DONE` is combinational, with zero added latency.

## Configuration
- `EF_PSRAM_INIT_QUAD_EN` defined:
  - Frame 2 (EQIO) is issued, leaving the device in SQI for the quad-mode controller.
  - 32 sck rising edges per sequence.
- `EF_PSRAM_INIT_QUAD_EN` undefined:
  - The sequence ends after WRMR; the device stays in SPI mode.
  - 24 sck rising edges per sequence; the EQIO state logic is not built.

## Test plan
- Defaults, quad enabled, reset release with the slave model attached:
  - ce_n falls exactly 3 times with low windows 5–38, 43–108, 113–146.
  - Captured bytes are FF, 01 40, 38.
  - done rises at cycle 150.
  - The slave model reports IOMode=quad.
- Macro undefined:
  - Bytes captured are FF, 01 40.
  - done at cycle 112.
  - The slave stays in SPI mode and 24 sck edges are counted.
- After done, drive ctrl_sck toggling, ctrl_ce_n=0, ctrl_dout=4'hA, ctrl_douten=4'hF:
  - Pads mirror these in the same cycle.
  - busy=0.
- Assert HRESETn low at cycle 60, during WRMR:
  - ce_n=1, sck=0 and douten=0 immediately.
  - After release, the full sequence reruns, with frame 0 starting at cycle 5 after release.
- In DONE, pulse start; also pulse start again during frame 1:
  - The sequence reruns once.
  - The second pulse is ignored.
  - done is low until completion, 150 cycles later with defaults.
- CLK_DIV=1, CE_GAP=1, MODE_REG=8'h00:
  - Frames are 17/33/17 cycles long.
  - done at cycle 71.
  - The WRMR data byte captured is 00.
